reg_file_2r1w: RTL



---
 rtl/pt1_cpu_pkg.sv | 6 +
 rtl/en_register.sv | 18 +
 rtl/reg_file_2r1w.sv | 44 ++++
 3 files changed

// File: rtl/pt1_cpu_pkg.sv
// pt1_cpu_pkg: shared datapath constants for the PT1 CPU
package pt1_cpu_pkg;
    localparam int CPU_WIDTH = 8;
    localparam int CPU_DEPTH = 8;
    localparam int REG_ZERO  = 0;
endpackage

// File: rtl/en_register.sv
// en_register: one register word with synchronous clear and load enable
module en_register
    import pt1_cpu_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // clear wins over load; otherwise hold
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: register file with one synchronous write port and two combinational read ports
module reg_file_2r1w
    import pt1_cpu_pkg::*;
#(
    parameter  int WIDTH    = CPU_WIDTH,
    parameter  int DEPTH    = CPU_DEPTH,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);
    logic [WIDTH-1:0] words [2**AW];
    logic             wr_ok;

    for (genvar g = 0; g < 2**AW; g++) begin : g_word
        if (g >= DEPTH || (ZERO_REG != 0 && g == REG_ZERO)) begin : g_tie
            assign words[g] = '0;
        end else begin : g_reg
            en_register #(.WIDTH(WIDTH)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (we && waddr == AW'(g)),
                .d     (wdata),
                .q     (words[g])
            );
        end
    end

    // unused and zero slots are tied to 0, so only the bypass needs a validity check
    always_comb begin
        wr_ok   = we && !reset && 32'(waddr) < DEPTH && !(ZERO_REG != 0 && waddr == AW'(REG_ZERO));
        rdata_a = (BYPASS != 0 && wr_ok && raddr_a == waddr) ? wdata : words[raddr_a];
        rdata_b = (BYPASS != 0 && wr_ok && raddr_b == waddr) ? wdata : words[raddr_b];
    end
endmodule
